// File: rtl/rrs_exec_core.sv
// Register-result-status (rename) table with CDB snooping, fused with a one-cycle add/multiply lane.
// Optional macro RRS_READ_BYPASS_EN forwards same-cycle table updates onto the read port.
module rrs_exec_core #(
  parameter int                NREG      = 64,
  parameter int                TAG_W     = 8,
  parameter int                DATA_W    = 32,
  parameter logic [TAG_W-1:0]  READY_TAG = TAG_W'(8'h7F),
  localparam int               ADDR_W    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_value,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_value,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              op_valid,
  input  logic              op_mul,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [TAG_W-1:0]  op_tag,
  output logic              res_valid,
  output logic [TAG_W-1:0]  res_tag,
  output logic [DATA_W-1:0] res_value
);

  logic [TAG_W-1:0]  tag_reg    [NREG];
  logic [DATA_W-1:0] value_reg  [NREG];
  logic [TAG_W-1:0]  tag_next   [NREG];
  logic [DATA_W-1:0] value_next [NREG];
  logic [NREG-1:0]   wr_hit;
  logic [NREG-1:0]   cdb_hit;

  wire wr_is_value = (wr_tag == READY_TAG);
  wire cdb_live    = cdb_valid && (cdb_tag != READY_TAG);

  // Per-entry next state; a rename on the same entry shadows any CDB match.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_entry
      assign wr_hit[gi]  = wr_en && (wr_addr == ADDR_W'(gi));
      assign cdb_hit[gi] = cdb_live && (tag_reg[gi] == cdb_tag);

      assign tag_next[gi] = wr_hit[gi]  ? wr_tag    :
                            cdb_hit[gi] ? READY_TAG : tag_reg[gi];

      assign value_next[gi] = wr_hit[gi]  ? (wr_is_value ? wr_value : value_reg[gi]) :
                              cdb_hit[gi] ? cdb_value : value_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        tag_reg[i]   <= READY_TAG;
        value_reg[i] <= '0;
      end
    end else begin
      tag_reg   <= tag_next;
      value_reg <= value_next;
    end
  end

  always_comb begin
    rd_tag   = tag_reg[rd_addr];
    rd_value = value_reg[rd_addr];
`ifdef RRS_READ_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_tag = wr_tag;
      if (wr_is_value) begin
        rd_value = wr_value;
      end
    end else if (cdb_hit[rd_addr]) begin
      rd_tag   = READY_TAG;
      rd_value = cdb_value;
    end
`endif
  end

  // Execution lane: low DATA_W bits of the signed product equal the wrapped result.
  logic              res_valid_reg;
  logic [TAG_W-1:0]  res_tag_reg;
  logic [DATA_W-1:0] res_value_reg;
  logic [DATA_W-1:0] sum_next;
  logic [DATA_W-1:0] prod_next;

  assign sum_next  = op_a + op_b;
  assign prod_next = DATA_W'($signed(op_a) * $signed(op_b));

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_reg <= 1'b0;
      res_tag_reg   <= '0;
      res_value_reg <= '0;
    end else begin
      res_valid_reg <= op_valid;
      if (op_valid) begin
        res_tag_reg   <= op_tag;
        res_value_reg <= op_mul ? prod_next : sum_next;
      end
    end
  end

  assign res_valid = res_valid_reg;
  assign res_tag   = res_tag_reg;
  assign res_value = res_value_reg;

endmodule

// File: tb/tb_rrs_exec_core.sv
// Self-checking bench for rrs_exec_core: spec-level model checked every cycle plus literal directed checks.
module tb_rrs_exec_core;
  localparam logic [7:0] RDY = 8'h7F;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_tag;
  logic [31:0] rd_value;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_tag;
  logic [31:0] wr_value;
  logic        cdb_valid;
  logic [7:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        op_valid;
  logic        op_mul;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [7:0]  op_tag;
  logic        res_valid;
  logic [7:0]  res_tag;
  logic [31:0] res_value;

  rrs_exec_core dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_tag(rd_tag), .rd_value(rd_value),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_tag(wr_tag), .wr_value(wr_value),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .op_valid(op_valid), .op_mul(op_mul), .op_a(op_a), .op_b(op_b), .op_tag(op_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_value(res_value)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  // Reference model: table as plain arrays, result as a simple expected triple.
  logic [7:0]  m_tag [64];
  logic [31:0] m_val [64];
  logic        e_valid;
  logic [7:0]  e_tag;
  logic [31:0] e_val;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        m_tag[i] <= RDY;
        m_val[i] <= 32'd0;
      end
      e_valid <= 1'b0;
      e_tag   <= 8'd0;
      e_val   <= 32'd0;
    end else begin
      for (int i = 0; i < 64; i++) begin
        if (wr_en && wr_addr == 6'(i)) begin
          m_tag[i] <= wr_tag;
          if (wr_tag == RDY) m_val[i] <= wr_value;
        end else if (cdb_valid && cdb_tag != RDY && m_tag[i] == cdb_tag) begin
          m_tag[i] <= RDY;
          m_val[i] <= cdb_value;
        end
      end
      e_valid <= op_valid;
      if (op_valid) begin
        longint pa;
        pa = longint'($signed(op_a)) * longint'($signed(op_b));
        e_tag <= op_tag;
        e_val <= op_mul ? pa[31:0] : op_a + op_b;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [7:0]  et;
      logic [31:0] ev;
      et = m_tag[rd_addr];
      ev = m_val[rd_addr];
`ifdef RRS_READ_BYPASS_EN
      if (wr_en && wr_addr == rd_addr) begin
        et = wr_tag;
        if (wr_tag == RDY) ev = wr_value;
      end else if (cdb_valid && cdb_tag != RDY && m_tag[rd_addr] == cdb_tag) begin
        et = RDY;
        ev = cdb_value;
      end
`endif
      check("model_rd_tag", 64'(rd_tag), 64'(et));
      check("model_rd_value", 64'(rd_value), 64'(ev));
      check("model_res_valid", 64'(res_valid), 64'(e_valid));
      check("model_res_tag", 64'(res_tag), 64'(e_tag));
      check("model_res_value", 64'(res_value), 64'(e_val));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1'b0; wr_en = 1'b0; cdb_valid = 1'b0; op_valid = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] t, input logic [31:0] v);
    wr_en = 1'b1; wr_addr = a; wr_tag = t; wr_value = v;
  endtask

  task automatic cdb(input logic [7:0] t, input logic [31:0] v);
    cdb_valid = 1'b1; cdb_tag = t; cdb_value = v;
  endtask

  task automatic op(input logic m, input logic [31:0] a, input logic [31:0] b, input logic [7:0] t);
    op_valid = 1'b1; op_mul = m; op_a = a; op_b = b; op_tag = t;
  endtask

  task automatic peek(input logic [5:0] a, input logic [7:0] et, input logic [31:0] ev, input string name);
    rd_addr = a;
    #1;
    check({name, "_tag"}, 64'(rd_tag), 64'(et));
    check({name, "_value"}, 64'(rd_value), 64'(ev));
  endtask

  task automatic res_chk(input logic v, input logic [7:0] t, input logic [31:0] x, input string name);
    check({name, "_valid"}, 64'(res_valid), 64'(v));
    check({name, "_tag"}, 64'(res_tag), 64'(t));
    check({name, "_value"}, 64'(res_value), 64'(x));
  endtask

  initial begin
    rst = 1'b1; rd_addr = 6'd0;
    wr_en = 1'b0; wr_addr = 6'd0; wr_tag = 8'd0; wr_value = 32'd0;
    cdb_valid = 1'b0; cdb_tag = 8'd0; cdb_value = 32'd0;
    op_valid = 1'b0; op_mul = 1'b0; op_a = 32'd0; op_b = 32'd0; op_tag = 8'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    cmp_en = 1'b1;

    for (int i = 0; i < 64; i++) peek(6'(i), 8'h7F, 32'd0, "reset_rd");
    res_chk(1'b0, 8'h00, 32'd0, "reset_res");

    wr(6'd5, 8'h7F, 32'd123); tick();
    wr(6'd5, 8'hA3, 32'd999); tick();
    peek(6'd5, 8'hA3, 32'd123, "rename_r5");
    cdb(8'hA3, 32'hFFFFFFF9); tick();
    peek(6'd5, 8'h7F, 32'hFFFFFFF9, "cdb_r5");

    wr(6'd3, 8'h42, 32'd0); tick();
    wr(6'd9, 8'h42, 32'd0); tick();
    peek(6'd3, 8'h42, 32'd0, "pend_r3");
    cdb(8'h42, 32'd55); tick();
    peek(6'd3, 8'h7F, 32'd55, "multi_r3");
    peek(6'd9, 8'h7F, 32'd55, "multi_r9");
    cdb(8'h7F, 32'd9); tick();
    peek(6'd0, 8'h7F, 32'd0, "cdbready_r0");
    peek(6'd3, 8'h7F, 32'd55, "cdbready_r3");

    wr(6'd7, 8'h80, 32'd0); tick();
    wr(6'd11, 8'h80, 32'd0); tick();
    wr(6'd7, 8'hC1, 32'd77); cdb(8'h80, 32'd1); tick();
    peek(6'd7, 8'hC1, 32'd0, "conflict_r7");
    peek(6'd11, 8'h7F, 32'd1, "conflict_r11");

    op(1'b0, 32'h7FFFFFFF, 32'd1, 8'hA0); tick();
    res_chk(1'b1, 8'hA0, 32'h80000000, "add_wrap");
    op(1'b1, 32'hFFFFFFFD, 32'd5, 8'hC2); tick();
    res_chk(1'b1, 8'hC2, 32'hFFFFFFF1, "mul_neg");
    op(1'b1, 32'h00010000, 32'h00010000, 8'hC3); tick();
    res_chk(1'b1, 8'hC3, 32'd0, "mul_ovf");
    op(1'b0, 32'd2, 32'd3, 8'hC4); tick();
    res_chk(1'b1, 8'hC4, 32'd5, "b2b_add");
    tick();
    res_chk(1'b0, 8'hC4, 32'd5, "idle_hold");

    for (int k = 0; k < 40; k++) begin
      op(k[0], 32'(k * 32'h01234567), 32'(32'd7 - 32'(k)), 8'(k + 8'h10));
      if (k % 3 == 0) wr(6'(k % 8), (k % 2 == 0) ? 8'h7F : 8'(8'h20 + k % 4), 32'(k * 11));
      if (k % 4 == 1) cdb(8'(8'h20 + k % 4), 32'(k * 13));
      rd_addr = 6'(k % 8);
      tick();
    end

    op(1'b0, 32'd1, 32'd1, 8'hD0); tick();
    res_chk(1'b1, 8'hD0, 32'd2, "pre_rst");
    rst = 1'b1; op(1'b1, 32'd3, 32'd3, 8'hD1); wr(6'd9, 8'h11, 32'd4); cdb(8'h7F, 32'd6); tick();
    res_chk(1'b0, 8'h00, 32'd0, "rst_res");
    peek(6'd5, 8'h7F, 32'd0, "rst_r5");
    peek(6'd9, 8'h7F, 32'd0, "rst_r9");

`ifdef RRS_READ_BYPASS_EN
    rd_addr = 6'd2; wr(6'd2, 8'h7F, 32'd8);
    #1;
    check("bypass_r2_value", 64'(rd_value), 64'd8);
    check("bypass_r2_tag", 64'(rd_tag), 64'h7F);
    tick();
`endif
    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
